// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Trial subtraction reuses the adder form: R + ~D + 1, carry out selects.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             divByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] trial;
  logic             take;
  logic [WIDTH:0]   r_new;
  logic [WIDTH-1:0] q_new;
  logic             r_new_top_unused;

  // Shifted partial remainder keeps the bit that leaves the top of R.
  assign r_sh  = {rem_q, quo_q[WIDTH-1]};
  assign trial = {1'b0, r_sh}
               + {1'b0, ~{1'b0, dsr_q}}
               + {{(WIDTH+1){1'b0}}, 1'b1};
  assign take  = trial[WIDTH+1];
  assign r_new = take ? trial[WIDTH:0] : r_sh;
  assign q_new = {quo_q[WIDTH-2:0], take};

  // After a restore the remainder is below D, so this bit is always 0.
  assign r_new_top_unused = r_new[WIDTH];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    qout_d  = qout_q;
    rout_d  = rout_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (divisor == '0) begin
            qout_d  = '1;
            rout_d  = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = dividend;
            dsr_d   = divisor;
            cnt_d   = CW'(WIDTH);
            dbz_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d = r_new[WIDTH-1:0];
        quo_d = q_new;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          qout_d  = q_new;
          rout_d  = r_new[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      qout_q  <= '0;
      rout_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient  = qout_q;
  assign remainder = rout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign divByZero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: timing/arithmetic model, per-cycle compare,
// directed cases and a randomized operand sweep.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         divByZero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: edge index counter, accept edge, done edge and held results.
  int unsigned  m_cyc, m_acc, m_done, nxt;
  bit           m_pend;
  bit           m_idle;
  logic [W-1:0] m_q, m_r, p_q, p_r, m_a, m_b;
  logic         m_z;

  assign nxt    = m_cyc + 1;
  assign m_idle = !m_pend || (nxt >= m_done + 2);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc  <= 0;
      m_acc  <= 0;
      m_done <= 0;
      m_pend <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      p_q    <= '0;
      p_r    <= '0;
      m_a    <= '0;
      m_b    <= '0;
      m_z    <= 1'b0;
    end else begin
      m_cyc <= nxt;
      if (m_pend && nxt == m_done) begin
        m_q <= p_q;
        m_r <= p_r;
      end
      if (m_idle && start) begin
        m_pend <= 1'b1;
        m_acc  <= nxt;
        m_a    <= dividend;
        m_b    <= divisor;
        if (divisor == 0) begin
          m_done <= nxt;
          m_q    <= '1;
          m_r    <= dividend;
          m_z    <= 1'b1;
        end else begin
          m_done <= nxt + W;
          p_q    <= dividend / divisor;
          p_r    <= dividend % divisor;
          m_z    <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy),
        64'(m_pend && m_cyc >= m_acc && m_cyc <= m_done));
    chk("done", 64'(done), 64'(m_pend && m_cyc == m_done));
    chk("quotient", 64'(quotient), 64'(m_q));
    chk("remainder", 64'(remainder), 64'(m_r));
    chk("divByZero", 64'(divByZero), 64'(m_z));
    if (!rst && done === 1'b1 && m_b != 0) begin
      chk("invariant",
          64'(int'(quotient) * int'(m_b) + int'(remainder)),
          64'(m_a));
      chk("rem_lt_div", 64'(remainder < m_b), 64'd1);
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    bit got;
    got = 1'b0;
    n   = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic next_slot;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int dn;
    logic [W-1:0] a, b;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_quotient", 64'(quotient), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    next_slot();
    do_op(8'd100, 8'd7);
    wait_done(n);
    chk("lat_100_7", 64'(n), 64'd9);
    chk("q_100_7", 64'(quotient), 64'd14);
    chk("r_100_7", 64'(remainder), 64'd2);
    chk("z_100_7", 64'(divByZero), 64'd0);

    next_slot();
    do_op(8'd255, 8'd1);
    wait_done(n);
    chk("q_255_1", 64'(quotient), 64'd255);
    chk("r_255_1", 64'(remainder), 64'd0);

    next_slot();
    do_op(8'd5, 8'd9);
    wait_done(n);
    chk("lat_b2b", 64'(n), 64'd9);
    chk("q_5_9", 64'(quotient), 64'd0);
    chk("r_5_9", 64'(remainder), 64'd5);

    next_slot();
    do_op(8'd200, 8'd0);
    wait_done(n);
    chk("lat_div0", 64'(n), 64'd1);
    chk("q_div0", 64'(quotient), 64'd255);
    chk("r_div0", 64'(remainder), 64'd200);
    chk("z_div0", 64'(divByZero), 64'd1);

    next_slot();
    do_op(8'd9, 8'd3);
    wait_done(n);
    chk("q_9_3", 64'(quotient), 64'd3);
    chk("r_9_3", 64'(remainder), 64'd0);
    chk("z_9_3", 64'(divByZero), 64'd0);

    next_slot();
    do_op(8'd100, 8'd7);
    next_slot();
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    next_slot();
    start = 1'b0;
    wait_done(n);
    chk("lat_ignored", 64'(n), 64'd7);
    chk("q_ignored", 64'(quotient), 64'd14);
    chk("r_ignored", 64'(remainder), 64'd2);

    repeat (3) next_slot();
    do_op(8'd255, 8'd16);
    repeat (2) next_slot();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_q", 64'(quotient), 64'd0);
    chk("abort_r", 64'(remainder), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    next_slot();
    rst = 1'b0;
    dn  = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);

    next_slot();
    do_op(8'd255, 8'd16);
    wait_done(n);
    chk("lat_255_16", 64'(n), 64'd9);
    chk("q_255_16", 64'(quotient), 64'd15);
    chk("r_255_16", 64'(remainder), 64'd15);

    for (int k = 0; k < 1000; k++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(1, 255));
      next_slot();
      do_op(a, b);
      dividend = W'($urandom);
      divisor  = W'($urandom);
      wait_done(n);
      chk("lat_rand", 64'(n), 64'(W + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider for the arithmetic unit.
- It is the inverse counterpart of the team's carry-lookahead adder blocks.
- Each cycle it forms a trial subtraction with the adder datapath: divisor operand inverted, carryInput = 1. The carry out decides one quotient bit.
- Operands are accepted with a start/done handshake. It sits beside the adders in the ALU as the slow-path divide unit.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend; sampled with start.
- divisor  input  WIDTH  unsigned divisor; sampled with start.
- quotient  output  WIDTH  result quotient; registered.
- remainder  output  WIDTH  result remainder; registered.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when results are valid.
- divByZero  output  1  set when the accepted divisor was 0; held with the results.

Behaviour:
- Reset (async, active-high, immediate):
  - state = IDLE.
  - quotient = 0, remainder = 0, busy = 0, done = 0, divByZero = 0.
  - Internal count = 0.
  - Reset mid-operation aborts the divide. No done pulse is issued.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE, start = 1, divisor != 0:
  - Load internal remainder accumulator R (WIDTH+1 bits) = 0.
  - Load internal Q = dividend and D = divisor.
  - count = WIDTH, clear divByZero, go to RUN.
- IDLE, start = 1, divisor == 0:
  - quotient = all ones, remainder = dividend, divByZero = 1.
  - Go directly to DONE; no RUN cycles.
- RUN, each cycle:
  - Shift {R, Q} left by 1.
  - Trial T = R_shifted + ~{0, D} + 1 (WIDTH+1 bits).
  - If carry out = 1 (T >= 0): R = T, and Q[0] = 1.
  - Else: keep R_shifted, and Q[0] = 0.
  - Decrement count. When count reaches 1 in the current cycle, go to DONE.
  - RUN therefore lasts exactly WIDTH cycles.
- DONE:
  - On entry, quotient = Q and remainder = R[WIDTH-1:0].
  - done = 1 for exactly one cycle, then return to IDLE.
- Latency:
  - Normal divide: done is high in cycle N+WIDTH+1, where start is sampled at edge N.
  - Divide by zero: done is high in cycle N+1.
- busy is 1 from the edge after start is accepted until the edge after done. It is 0 in IDLE.
- start while busy = 1 is ignored. dividend/divisor changes during RUN have no effect.
- start is accepted in the IDLE cycle immediately after DONE, so back-to-back operations are supported.
- quotient, remainder and divByZero hold their last values until the next DONE or reset.
- Arithmetic is unsigned. The R bit above WIDTH absorbs the shifted-out bit, so there is no overflow for any operands.
- Invariant: dividend = quotient*divisor + remainder, and remainder < divisor (when divisor != 0).

Test Plan:
- WIDTH=8, dividend=100, divisor=7, one-cycle start → done pulses 9 cycles after the start edge; quotient=14, remainder=2, divByZero=0; busy high for 9 cycles.
- dividend=255, divisor=1 → quotient=255, remainder=0. Then dividend=5, divisor=9, start in the cycle right after done → quotient=0, remainder=5 (back-to-back accepted).
- dividend=200, divisor=0 → done 1 cycle after start; quotient=255, remainder=200, divByZero=1. A following 9/3 → quotient=3, remainder=0, divByZero cleared.
- Start 100/7, then at cycle 3 pulse start with 50/5 and change the operand inputs → the second start is ignored; the result is still 14 r 2 and only one done pulse occurs.
- Start 255/16, assert rst at cycle 4 for 1 cycle → all outputs 0 immediately and no done pulse. A restarted 255/16 → quotient=15, remainder=15.
- Random sweep, 1000 operand pairs (divisor != 0) → the invariant holds and latency is always WIDTH+1.
